swipt_output_guard: RTL and testbench

Output safety and dead-time stage between the full-bridge `Pwm` generator and the `SWIPT_OUT0..3` pins. Takes the four raw switch commands plus the tracker's enable and the heartbeat `swiptAlive` flag, and inserts programmable dead time per half-bridge leg. It blocks shoot-through, applies an arming delay before the first switching edge, and latches a fault on an illegal command. Pins are driven only from the RUN state.

---
 rtl/swipt_pkg.sv | 14 +
 rtl/swipt_output_guard_if.sv | 28 ++
 rtl/deadtime_leg.sv | 55 +++++
 rtl/swipt_output_guard.sv | 97 +++++++++
 tb/tb_swipt_output_guard.sv | 138 +++++++++++++
 5 files changed

// File: rtl/swipt_pkg.sv
// Shared types and widths for the SWIPT output guard and its dead-time legs.
package swipt_pkg;

  localparam int DT_W  = 8;
  localparam int ARM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } guard_state_t;

endpackage

// File: rtl/swipt_output_guard_if.sv
// Raw switch commands, control flags and guarded pin drives between Pwm and the output guard.
interface swipt_output_guard_if;

  logic        i_s1;
  logic        i_s2;
  logic        i_s3;
  logic        i_s4;
  logic        i_enable;
  logic        i_alive;
  logic        i_clear_fault;
  logic        o_out0;
  logic        o_out1;
  logic        o_out2;
  logic        o_out3;
  logic        o_fault;
  logic [31:0] o_db_state;

  modport master (
    output i_s1, i_s2, i_s3, i_s4, i_enable, i_alive, i_clear_fault,
    input  o_out0, o_out1, o_out2, o_out3, o_fault, o_db_state
  );

  modport slave (
    input  i_s1, i_s2, i_s3, i_s4, i_enable, i_alive, i_clear_fault,
    output o_out0, o_out1, o_out2, o_out3, o_fault, o_db_state
  );

endinterface

// File: rtl/deadtime_leg.sv
// One half-bridge leg: any change of the {hi,lo} command forces both switches low for
// DEADTIME_CYCLES clocks; outputs are registered, so turn-on lands DEADTIME_CYCLES+1 clocks later.
module deadtime_leg
  import swipt_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_hi,
  input  logic i_lo,
  output logic o_hi,
  output logic o_lo
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYCLES);

  logic [1:0]      cmd;
  logic [1:0]      prev_q;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  assign cmd = {i_hi, i_lo};

  always_comb begin
    cnt_d = cnt_q;
    if (cmd != prev_q) begin
      cnt_d = DT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // Mask on the next count so a fresh change drops the pins on the very edge that sees it.
    hi_d = (cnt_d == '0) & i_hi;
    lo_d = (cnt_d == '0) & i_lo;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      prev_q <= cmd;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: rtl/swipt_output_guard.sv
// Output safety stage: IDLE/ARM/RUN/FAULT sequencing, arming delay and shoot-through latch
// in front of two dead-time legs; pins are driven only while in RUN.
module swipt_output_guard
  import swipt_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 8,
  parameter int ARM_CYCLES      = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  swipt_output_guard_if.slave  bus
);

  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  guard_state_t     state_q, state_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             go;
  logic             shoot;
  logic             run;
  logic             a_hi, a_lo, b_hi, b_lo;

  assign go    = bus.i_enable & bus.i_alive;
  assign shoot = (bus.i_s1 & bus.i_s2) | (bus.i_s3 & bus.i_s4);

  deadtime_leg #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_leg_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hi    (bus.i_s1),
    .i_lo    (bus.i_s2),
    .o_hi    (a_hi),
    .o_lo    (a_lo)
  );

  deadtime_leg #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_leg_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hi    (bus.i_s3),
    .i_lo    (bus.i_s4),
    .o_hi    (b_hi),
    .o_lo    (b_lo)
  );

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      ST_IDLE: begin
        arm_cnt_d = '0;
        if (go) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!go) begin
          state_d   = ST_IDLE;
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d   = ST_RUN;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!go) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (bus.i_clear_fault && !bus.i_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Shoot-through overrides everything, including a concurrent fault clear.
    if (shoot) begin
      state_d   = ST_FAULT;
      arm_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign run = (state_q == ST_RUN);

  assign bus.o_out0     = a_hi & run;
  assign bus.o_out1     = a_lo & run;
  assign bus.o_out2     = b_hi & run;
  assign bus.o_out3     = b_lo & run;
  assign bus.o_fault    = (state_q == ST_FAULT);
  assign bus.o_db_state = (state_q == ST_ARM) ? {16'd0, arm_cnt_q} : {30'd0, state_q};

endmodule

// File: tb/tb_swipt_output_guard.sv
// Directed bench for swipt_output_guard with DEADTIME_CYCLES=4, ARM_CYCLES=20.
module tb_swipt_output_guard;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  swipt_output_guard_if bus ();

  swipt_output_guard #(.DEADTIME_CYCLES(4), .ARM_CYCLES(20)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {28'd0, bus.o_out3, bus.o_out2, bus.o_out1, bus.o_out0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_s1 = 0; bus.i_s2 = 0; bus.i_s3 = 0; bus.i_s4 = 0;
    bus.i_enable = 0; bus.i_alive = 0; bus.i_clear_fault = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_outs",  outs(), 32'h0);
    chk("rst_fault", {31'd0, bus.o_fault}, 32'h0);
    chk("rst_db",    bus.o_db_state, 32'h0);
    step();
    chk("idle_db", bus.o_db_state, 32'h0);

    // Arming: enable, alive and static s1/s4 all raised together.
    bus.i_s1 = 1; bus.i_s4 = 1; bus.i_enable = 1; bus.i_alive = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("arm_outs_low", outs(), 32'h0);
      chk("arm_db_cnt",   bus.o_db_state, 32'(k - 1));
    end
    step();
    chk("arm_first_high", outs(), 32'h9);
    chk("arm_run_db",     bus.o_db_state, 32'd2);

    // Dead time on leg A: hi -> lo.
    bus.i_s1 = 0; bus.i_s2 = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("dt_both_low", outs(), 32'h8);
    end
    step();
    chk("dt_lo_on", outs(), 32'ha);

    // Retrigger leg A every 2 cycles: it must never come out of dead time.
    for (int t = 0; t < 5; t++) begin
      bus.i_s1 = ~bus.i_s1; bus.i_s2 = ~bus.i_s2;
      step();
      chk("retrig_low_a", outs(), 32'h8);
      step();
      chk("retrig_low_b", outs(), 32'h8);
    end
    repeat (4) step();
    chk("retrig_settled", outs(), 32'h9);

    // Shoot-through on leg B for one cycle.
    bus.i_s3 = 1;
    step();
    chk("st_fault",  {31'd0, bus.o_fault}, 32'h1);
    chk("st_db",     bus.o_db_state, 32'd3);
    chk("st_outs",   outs(), 32'h0);
    bus.i_s3 = 0;
    repeat (6) step();
    chk("st_hold_outs",  outs(), 32'h0);
    chk("st_hold_fault", {31'd0, bus.o_fault}, 32'h1);

    bus.i_clear_fault = 1;
    step(); step();
    chk("clr_en_ignored", bus.o_db_state, 32'd3);
    chk("clr_en_fault",   {31'd0, bus.o_fault}, 32'h1);

    bus.i_enable = 0; bus.i_s3 = 1;
    step();
    chk("clr_vs_shoot", bus.o_db_state, 32'd3);
    bus.i_s3 = 0;
    step();
    chk("clr_idle_db",    bus.o_db_state, 32'd0);
    chk("clr_idle_fault", {31'd0, bus.o_fault}, 32'h0);
    bus.i_clear_fault = 0;

    // Re-arm into RUN, then lose the heartbeat.
    bus.i_enable = 1;
    repeat (20) step();
    chk("rearm_still_low", outs(), 32'h0);
    step();
    chk("rearm_high", outs(), 32'h9);
    bus.i_alive = 0;
    step();
    chk("hb_outs", outs(), 32'h0);
    chk("hb_db",   bus.o_db_state, 32'd0);
    bus.i_alive = 1;
    step();
    chk("hb_arm_db", bus.o_db_state, 32'd0);
    step();
    chk("hb_arm_cnt", bus.o_db_state, 32'd1);
    repeat (18) step();
    chk("hb_full_delay_low", outs(), 32'h0);
    step();
    chk("hb_full_delay_high", outs(), 32'h9);

    // Asynchronous reset mid-RUN, away from any clock edge.
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", outs(), 32'h0);
    step();
    rst = 1'b0;
    chk("rst_release_db",    bus.o_db_state, 32'd0);
    chk("rst_release_fault", {31'd0, bus.o_fault}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
